// File: rtl/usb_rx_pkg.sv
// -----------------------------------------------------------------------------
// usb_rx_pkg
// Shared constants and types for the USB full-speed receive path.
//   BITS_PER_BYTE     data bits per byte (stuffed bits never counted)
//   DEF_CLKS_PER_BIT  default system clocks per USB bit time
//   DEF_SAMPLE_POINT  default phase at which a bit is sampled
//   PHASE_W           width of the bit-phase counter (covers up to 15 clocks)
// -----------------------------------------------------------------------------
package usb_rx_pkg;

    localparam int BITS_PER_BYTE    = 8;
    localparam int DEF_CLKS_PER_BIT = 8;
    localparam int DEF_SAMPLE_POINT = 3;
    localparam int PHASE_W          = 4;
    localparam int BIT_CNT_W        = $clog2(BITS_PER_BYTE);

    typedef logic [PHASE_W-1:0]   phase_t;
    typedef logic [BIT_CNT_W-1:0] bit_cnt_t;

endpackage : usb_rx_pkg

// File: rtl/rx_phase_counter.sv
// -----------------------------------------------------------------------------
// rx_phase_counter
// Loadable wrap counter tracking the phase within one USB bit time.
// Priority: clear > load > enable. When enabled it counts 0..WRAP-1 and wraps.
//   clk       system clock
//   n_rst     asynchronous active-low reset
//   clear     synchronous clear to 0
//   load      synchronous load of load_val
//   load_val  value loaded when load is high
//   enable    count enable
//   phase     current phase
// -----------------------------------------------------------------------------
module rx_phase_counter
    import usb_rx_pkg::*;
#(
    parameter int WRAP = DEF_CLKS_PER_BIT
) (
    input  logic   clk,
    input  logic   n_rst,
    input  logic   clear,
    input  logic   load,
    input  phase_t load_val,
    input  logic   enable,
    output phase_t phase
);

    localparam phase_t LAST = phase_t'(WRAP - 1);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            phase <= '0;
        end else if (clear) begin
            phase <= '0;
        end else if (load) begin
            phase <= load_val;
        end else if (enable) begin
            phase <= (phase == LAST) ? '0 : phase + 1'b1;
        end
    end

endmodule : rx_phase_counter

// File: rtl/timer_decode.sv
// -----------------------------------------------------------------------------
// timer_decode
// Receive-side bit/byte timer for the USB full-speed receiver. Tracks bit
// phase, re-aligns it on every line transition, strobes the shift register
// at the sample point and pulses once per 8 counted (non-stuffed) bits.
//   clk            system clock
//   n_rst          asynchronous active-low reset
//   rcving         packet reception in progress
//   d_edge         single-cycle line transition pulse
//   stuff_skip     bit sampled this cycle is a stuffed bit
//   clear          synchronous clear of all counters
//   shift_enable   sample/shift strobe to the receive shift register
//   byte_received  one-cycle pulse after the 8th counted bit
//   bit_count      counted bits in the current byte
// -----------------------------------------------------------------------------
module timer_decode
    import usb_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int SAMPLE_POINT = DEF_SAMPLE_POINT
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       rcving,
    input  logic       d_edge,
    input  logic       stuff_skip,
    input  logic       clear,
    output logic       shift_enable,
    output logic       byte_received,
    output logic [2:0] bit_count
);

    localparam phase_t   SAMPLE_PHASE = phase_t'(SAMPLE_POINT);
    // An edge cycle counts as phase 0 of the new bit, so the cycle after
    // it is phase 1.
    localparam phase_t   EDGE_RELOAD  = phase_t'(1);
    localparam bit_cnt_t LAST_BIT     = bit_cnt_t'(BITS_PER_BYTE - 1);

    phase_t phase;
    logic   hold;
    logic   counted;

    // Idle or explicit clear parks every counter at zero.
    assign hold = !rcving || clear;

    rx_phase_counter #(
        .WRAP (CLKS_PER_BIT)
    ) u_phase (
        .clk      (clk),
        .n_rst    (n_rst),
        .clear    (hold),
        .load     (d_edge),
        .load_val (EDGE_RELOAD),
        .enable   (rcving),
        .phase    (phase)
    );

    // Decoded from registered phase only: an edge landing on the sample
    // cycle still samples, and the resync shows up one cycle later.
    assign shift_enable = rcving && !clear && (phase == SAMPLE_PHASE);

    assign counted = shift_enable && !stuff_skip;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bit_count     <= '0;
            byte_received <= 1'b0;
        end else if (hold) begin
            bit_count     <= '0;
            byte_received <= 1'b0;
        end else begin
            // Byte completes when the 8th counted bit wraps the counter;
            // the counter runs straight on into the next byte.
            byte_received <= counted && (bit_count == LAST_BIT);
            if (counted) begin
                bit_count <= bit_count + 1'b1;
            end
        end
    end

endmodule : timer_decode

// File: tb/tb_timer_decode.sv
module tb_timer_decode;

    localparam int CPB = 8;
    localparam int SP  = 3;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       rcving = 1'b0;
    logic       d_edge = 1'b0;
    logic       stuff_skip = 1'b0;
    logic       clear = 1'b0;
    logic       shift_enable;
    logic       byte_received;
    logic [2:0] bit_count;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: cycles since the current bit started, total counted
    // bits since the last clear, and a pending byte pulse.
    int m_t = 0;
    int m_cnt = 0;
    bit m_pend = 1'b0;

    // DUT outputs as seen in the most recent step.
    bit obs_se, obs_br;
    int obs_bc;

    timer_decode #(
        .CLKS_PER_BIT (CPB),
        .SAMPLE_POINT (SP)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .rcving        (rcving),
        .d_edge        (d_edge),
        .stuff_skip    (stuff_skip),
        .clear         (clear),
        .shift_enable  (shift_enable),
        .byte_received (byte_received),
        .bit_count     (bit_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_t = 0;
        m_cnt = 0;
        m_pend = 1'b0;
    endtask

    // One clock: drive inputs after the falling edge, compare against the
    // model, then advance the model across the coming rising edge.
    task automatic step(input logic r, input logic e, input logic s, input logic c);
        bit exp_se;
        bit counted;
        @(negedge clk);
        rcving = r;
        d_edge = e;
        stuff_skip = s;
        clear = c;
        #1;
        exp_se = rcving && !clear && ((m_t % CPB) == SP);
        obs_se = shift_enable;
        obs_br = byte_received;
        obs_bc = int'(bit_count);
        check("shift_enable", int'(shift_enable), int'(exp_se));
        check("bit_count", int'(bit_count), m_cnt % 8);
        check("byte_received", int'(byte_received), int'(m_pend));
        if (!n_rst || !rcving || clear) begin
            m_reset();
        end else begin
            counted = exp_se && !stuff_skip;
            m_pend = counted && ((m_cnt % 8) == 7);
            if (counted) m_cnt++;
            m_t = d_edge ? 1 : m_t + 1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    int n_se, br_cnt, first_br;
    int exp_b[3];
    bit rx_on;
    int gap;
    bit re, ee, se, ce;

    initial begin
        // Reset state
        #2;
        check("reset_se", int'(shift_enable), 0);
        check("reset_bc", int'(bit_count), 0);
        check("reset_br", int'(byte_received), 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        n_rst = 1'b1;
        idle(3);

        // Steady reception: edges every 8 cycles, 8 bits
        n_se = 0; br_cnt = 0; first_br = -1;
        for (int k = 0; k < 64; k++) begin
            step(1'b1, (k % 8) == 0, 1'b0, 1'b0);
            if (obs_se) begin
                if (n_se < 8) check("steady_strobe_pos", k, 3 + 8 * n_se);
                n_se++;
            end
            if (obs_br) begin br_cnt++; if (first_br < 0) first_br = k; end
            if (k == 60) check("steady_bc_after_byte", obs_bc, 0);
        end
        check("steady_strobe_count", n_se, 8);
        check("steady_br_count", br_cnt, 1);
        check("steady_br_pos", first_br, 60);
        idle(3);

        // Resync: edge at phase 6 pulls the next strobe in to edge+3
        exp_b = '{3, 11, 17};
        n_se = 0;
        for (int k = 0; k < 24; k++) begin
            step(1'b1, (k == 0) || (k == 8) || (k == 14), 1'b0, 1'b0);
            if (obs_se) begin
                if (n_se < 3) check("resync_strobe_pos", k, exp_b[n_se]);
                n_se++;
            end
        end
        check("resync_strobe_count", n_se, 3);
        idle(3);

        // Stuffed 4th bit: count holds, byte after the 9th strobe
        br_cnt = 0; first_br = -1;
        for (int k = 0; k < 72; k++) begin
            step(1'b1, (k % 8) == 0, k == 27, 1'b0);
            if (k == 27) check("stuff_strobe_present", int'(obs_se), 1);
            if (k == 28) check("stuff_bc_hold", obs_bc, 3);
            if (obs_br) begin br_cnt++; if (first_br < 0) first_br = k; end
        end
        check("stuff_br_count", br_cnt, 1);
        check("stuff_br_pos", first_br, 68);
        idle(3);

        // Clear on the 8th strobe: no pulse, count zero
        br_cnt = 0;
        for (int k = 0; k < 64; k++) begin
            step(1'b1, (k % 8) == 0, 1'b0, k == 59);
            if (k == 58) check("clear_bc_before", obs_bc, 7);
            if (k == 59) check("clear_se_masked", int'(obs_se), 0);
            if (k == 60) check("clear_bc_after", obs_bc, 0);
            if (obs_br) br_cnt++;
        end
        check("clear_br_count", br_cnt, 0);
        idle(3);

        // rcving drops after 5 bits
        br_cnt = 0;
        for (int k = 0; k < 42; k++) begin
            step(k < 38, ((k % 8) == 0) && (k < 38), 1'b0, 1'b0);
            if (k == 36) check("drop_bc_before", obs_bc, 5);
            if (k == 39) check("drop_bc_after", obs_bc, 0);
            if (obs_br) br_cnt++;
        end
        check("drop_br_count", br_cnt, 0);
        idle(3);

        // Glitch edges on 3 consecutive cycles
        first_br = -1;
        for (int k = 0; k < 12; k++) begin
            step(1'b1, k < 3, 1'b0, 1'b0);
            if (obs_se && first_br < 0) first_br = k;
        end
        check("glitch_first_strobe", first_br, 5);
        idle(3);

        // Asynchronous reset mid-byte at phase 5, bit_count 4
        for (int k = 0; k < 30; k++) begin
            step(1'b1, (k % 8) == 0, 1'b0, 1'b0);
            if (k == 29) check("rst_bc_before", obs_bc, 4);
        end
        #2;
        n_rst = 1'b0;
        m_reset();
        #1;
        check("rst_async_se", int'(shift_enable), 0);
        check("rst_async_bc", int'(bit_count), 0);
        check("rst_async_br", int'(byte_received), 0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        n_rst = 1'b1;
        br_cnt = 0;
        for (int k = 0; k < 24; k++) begin
            step(1'b1, (k % 8) == 0, 1'b0, 1'b0);
            if (obs_br) br_cnt++;
        end
        check("rst_no_br_after", br_cnt, 0);
        idle(3);

        // Randomized run against the model
        rx_on = 1'b1;
        gap = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 199) == 0) rx_on = !rx_on;
            re = rx_on;
            gap--;
            ee = 1'b0;
            if (gap <= 0) begin
                ee = 1'b1;
                gap = CPB - 1 + $urandom_range(0, 2);
            end else if ($urandom_range(0, 47) == 0) begin
                ee = 1'b1;
            end
            se = ($urandom_range(0, 5) == 0);
            ce = ($urandom_range(0, 99) == 0);
            step(re, ee, se, ce);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_timer_decode

// File: doc/timer_decode.md
Name: timer_decode

Overview:
Receive-side bit/byte timer for the USB full-speed receiver; counterpart of the transmitter's encode timer. It tracks bit phase at CLKS_PER_BIT system clocks per USB bit and re-aligns that phase on every detected line transition. It emits a mid-bit sample strobe to the receive shift register and a one-cycle pulse when 8 data bits (stuffed bits excluded) have been sampled. Sits between the edge detector/stuff detector and the receive shift register and RX controller FSM.

Parameters:
CLKS_PER_BIT, 8, system clocks per USB bit time (legal 4..15)
SAMPLE_POINT, 3, phase value at which the bit is sampled (legal 1..CLKS_PER_BIT-2)

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
rcving  input  1  RX controller: packet reception in progress
d_edge  input  1  single-cycle pulse: transition detected on D+/D- this cycle
stuff_skip  input  1  stuff detector: bit sampled this cycle is a stuffed bit, do not count it
clear  input  1  synchronous clear of all counters (byte boundary realign, e.g. after SYNC)
shift_enable  output  1  sample/shift strobe to receive shift register
byte_received  output  1  one-cycle pulse: 8 counted bits complete
bit_count  output  3  counted bits in the current byte, 0..7

Behaviour:
- One clock domain, clk rising edge; n_rst asynchronous active-low.
- Reset: phase=0, bit_count=0, byte_received=0; shift_enable=0 (rcving low out of reset).
- Phase counter, width 4:
  - rcving=0 or clear=1: phase loads 0 next cycle; clear has highest priority.
  - Else d_edge=1: phase loads 1 next cycle. The edge cycle is treated as phase 0 of the new bit.
  - Else: phase increments; CLKS_PER_BIT-1 wraps to 0.
  - On the first cycle rcving is high, phase is 0. The first strobe follows SAMPLE_POINT cycles later, or SAMPLE_POINT cycles after the first edge.
- shift_enable = rcving and not clear and (phase == SAMPLE_POINT).
  - Combinational decode of registered state only; no dependence on d_edge.
  - An edge coinciding with the sample cycle still produces the strobe; the resync takes effect next cycle.
- Bit counter:
  - Increments on shift_enable and not stuff_skip.
  - After 7 it wraps to 0.
  - Zeroed by clear or rcving=0.
  - stuff_skip without shift_enable is ignored.
- byte_received:
  - Registered. High for exactly one cycle, the cycle after a counted shift_enable that took bit_count from 7 to 0.
  - Never asserted when clear or rcving=0 is in that same shift cycle.
- Reset or rcving falling mid-byte: partial byte discarded, counters zero next cycle, no byte_received.
- Back-to-back bytes: no gap cycles required; the counter continues straight into the next byte.
- Edges arriving faster than SAMPLE_POINT cycles apart (glitches): phase keeps reloading 1 and no strobe issues. This is legal and required.

Decomposition:
- Package usb_rx_pkg: BITS_PER_BYTE=8, default CLKS_PER_BIT and SAMPLE_POINT constants, phase width localparam.
- One sub-module: rx_phase_counter, a loadable wrap counter with clear/load/enable inputs and a phase output. It is required because the existing flex counter has no load input.
- Bit counter and pulse register live in the top level.

Test Plan:
- Reset mid-count: assert n_rst low asynchronously at phase 5, bit_count 4. Required: outputs 0 immediately, no byte_received after release.
- Steady reception: rcving=1, d_edge every 8 cycles, no stuff_skip, 8 bits. Required:
  - shift_enable at cycles 3,11,…,59 after the first edge.
  - byte_received exactly one cycle after the 8th strobe; bit_count returns to 0.
- Resync: clock drift with edge arriving at phase 6 instead of 0. Required: next strobe exactly 3 cycles after that edge, not 5.
- Stuffed bit: stuff_skip high on the 4th strobe of a byte. Required:
  - bit_count holds at 3.
  - byte_received only after the 9th strobe.
- Clear and rcving drop:
  - clear high in the same cycle as the 8th strobe. Required: no byte_received, bit_count 0.
  - rcving falls after 5 bits. Required: no pulse, counters 0.
- Glitch edges: d_edge on 3 consecutive cycles. Required: no shift_enable until SAMPLE_POINT cycles after the last edge.
